wb_pipe_stage: RTL and testbench

Parametrised MEM/WB pipeline register and writeback stage for the pipelined MIPS core. It accepts one retiring instruction per cycle from the memory stage and selects ALU result or load data. It drives a registered, single-cycle write pulse to the register file and keeps a sticky forwarding copy of the last write for the execute stage. It also maintains a retired-instruction counter.

---
 rtl/wb_pipe_stage.sv | 103 ++++++++++
 tb/tb_wb_pipe_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_stage.sv
// MEM/WB pipeline register: selects ALU or load data, issues a one-cycle register-file
// write, keeps a sticky forwarding copy of the last write and counts retired instructions.
// Optional load extraction/extension is built when WB_LOAD_EXT_EN is defined (DATA_W must be 32).
module wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [REG_AW-1:0] in_des_reg,
`ifdef WB_LOAD_EXT_EN
    input  logic [1:0]        in_load_size,
    input  logic              in_load_unsigned,
    input  logic [1:0]        in_byte_off,
`endif
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_count
);

    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wr_data;

    assign in_ready = !hold;
    assign accept   = in_valid && in_ready && !flush;

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        sign_bit;

    // Little-endian lanes: byte_off 0 selects bits 7:0.
    always_comb begin
        load_byte = in_read_data[7:0];
        case (in_byte_off)
            2'd0:    load_byte = in_read_data[7:0];
            2'd1:    load_byte = in_read_data[15:8];
            2'd2:    load_byte = in_read_data[23:16];
            default: load_byte = in_read_data[31:24];
        endcase
        load_half = in_byte_off[1] ? in_read_data[31:16] : in_read_data[15:0];
        sign_bit  = 1'b0;
        load_data = in_read_data;
        case (in_load_size)
            2'b00: begin
                sign_bit  = !in_load_unsigned && load_byte[7];
                load_data = {{24{sign_bit}}, load_byte};
            end
            2'b01: begin
                sign_bit  = !in_load_unsigned && load_half[15];
                load_data = {{16{sign_bit}}, load_half};
            end
            default: load_data = in_read_data;
        endcase
    end
`else
    assign load_data = in_read_data;
`endif

    assign wr_data = in_mem_to_reg ? load_data : in_alu_res;
    assign wr_en   = in_reg_write && (in_des_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            fwd_valid    <= 1'b0;
            fwd_reg      <= '0;
            fwd_data     <= '0;
            retire_count <= '0;
        end else if (accept) begin
            rf_we        <= wr_en;
            rf_waddr     <= in_des_reg;
            rf_wdata     <= wr_data;
            retire_count <= retire_count + CNT_W'(1);
            // Forwarding copy tracks only real writes and is otherwise sticky.
            if (wr_en) begin
                fwd_valid <= 1'b1;
                fwd_reg   <= in_des_reg;
                fwd_data  <= wr_data;
            end
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed self-checking bench for wb_pipe_stage; a second instance with CNT_W=4
// shares all inputs to exercise retire-counter wrap.
module tb_wb_pipe_stage;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [31:0] in_read_data;
    logic [31:0] in_alu_res;
    logic [4:0]  in_des_reg;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;
    logic [1:0]  in_byte_off;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic [31:0] retire_count;

    logic        in_ready4;
    logic        rf_we4;
    logic [4:0]  rf_waddr4;
    logic [31:0] rf_wdata4;
    logic        fwd_valid4;
    logic [4:0]  fwd_reg4;
    logic [31:0] fwd_data4;
    logic [3:0]  retire_count4;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    wb_pipe_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .hold             (hold),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_reg_write     (in_reg_write),
        .in_mem_to_reg    (in_mem_to_reg),
        .in_read_data     (in_read_data),
        .in_alu_res       (in_alu_res),
        .in_des_reg       (in_des_reg),
`ifdef WB_LOAD_EXT_EN
        .in_load_size     (in_load_size),
        .in_load_unsigned (in_load_unsigned),
        .in_byte_off      (in_byte_off),
`endif
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .fwd_valid        (fwd_valid),
        .fwd_reg          (fwd_reg),
        .fwd_data         (fwd_data),
        .retire_count     (retire_count)
    );

    wb_pipe_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) u_dut4 (
        .clk              (clk),
        .rst              (rst),
        .hold             (hold),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready4),
        .in_reg_write     (in_reg_write),
        .in_mem_to_reg    (in_mem_to_reg),
        .in_read_data     (in_read_data),
        .in_alu_res       (in_alu_res),
        .in_des_reg       (in_des_reg),
`ifdef WB_LOAD_EXT_EN
        .in_load_size     (in_load_size),
        .in_load_unsigned (in_load_unsigned),
        .in_byte_off      (in_byte_off),
`endif
        .rf_we            (rf_we4),
        .rf_waddr         (rf_waddr4),
        .rf_wdata         (rf_wdata4),
        .fwd_valid        (fwd_valid4),
        .fwd_reg          (fwd_reg4),
        .fwd_data         (fwd_data4),
        .retire_count     (retire_count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] rd);
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        in_read_data  = rdata;
        in_alu_res    = alu;
        in_des_reg    = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hold = 1'b0;
        flush = 1'b0;
        in_load_size = 2'b10;
        in_load_unsigned = 1'b0;
        in_byte_off = 2'b00;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h7, 5'd15);
        step();
        step();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== 38'h0) begin
            errors++;
            $display("FAIL reset_rf: got we=%b waddr=%0d wdata=%h exp all 0", rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if ({fwd_valid, fwd_reg, fwd_data} !== 38'h0) begin
            errors++;
            $display("FAIL reset_fwd: got v=%b reg=%0d data=%h exp all 0", fwd_valid, fwd_reg, fwd_data);
        end
        checks++;
        if (retire_count !== 32'd0 || retire_count4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d/%0d exp 0", retire_count, retire_count4);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_hold0: got %b exp 1", in_ready);
        end
        hold = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_hold1: got %b exp 0", in_ready);
        end
        hold = 1'b0;
        in_valid = 1'b0;
        rst = 1'b0;
        exp_cnt = 0;
        step();
    endtask

    task automatic test_alu_write();
        drive(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h7, 5'd15);
        step();
        exp_cnt++;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd15 || rf_wdata !== 32'h7) begin
            errors++;
            $display("FAIL alu_rf: got we=%b waddr=%0d wdata=%h exp 1/15/00000007", rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (fwd_valid !== 1'b1 || fwd_reg !== 5'd15 || fwd_data !== 32'h7) begin
            errors++;
            $display("FAIL alu_fwd: got %b/%0d/%h exp 1/15/00000007", fwd_valid, fwd_reg, fwd_data);
        end
        checks++;
        if (retire_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL alu_count: got %0d exp %0d", retire_count, exp_cnt);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd15 || rf_wdata !== 32'h7) begin
            errors++;
            $display("FAIL bubble_hold: got we=%b waddr=%0d wdata=%h exp 0/15/00000007", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_load_r0_nowrite();
        drive(1'b1, 1'b1, 1'b1, 32'h3, 32'h99, 5'd14);
        step();
        exp_cnt++;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd14 || rf_wdata !== 32'h3) begin
            errors++;
            $display("FAIL load_rf: got we=%b waddr=%0d wdata=%h exp 1/14/00000003", rf_we, rf_waddr, rf_wdata);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h5, 5'd0);
        step();
        exp_cnt++;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h5) begin
            errors++;
            $display("FAIL r0_rf: got we=%b waddr=%0d wdata=%h exp 0/0/00000005", rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (retire_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL r0_count: got %0d exp %0d", retire_count, exp_cnt);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h9, 5'd31);
        step();
        exp_cnt++;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd31) begin
            errors++;
            $display("FAIL nowrite_rf: got we=%b waddr=%0d exp 0/31", rf_we, rf_waddr);
        end
        checks++;
        if (fwd_valid !== 1'b1 || fwd_reg !== 5'd14 || fwd_data !== 32'h3) begin
            errors++;
            $display("FAIL nowrite_fwd: got %b/%0d/%h exp 1/14/00000003", fwd_valid, fwd_reg, fwd_data);
        end
        checks++;
        if (retire_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL nowrite_count: got %0d exp %0d", retire_count, exp_cnt);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_hold_flush();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h33, 5'd3);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rf_we !== 1'b0 || retire_count !== 32'(exp_cnt) || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got we=%b cnt=%0d ready=%b exp 0/%0d/0", i, rf_we, retire_count, in_ready, exp_cnt);
            end
        end
        hold = 1'b0;
        flush = 1'b1;
        step();
        checks++;
        if (rf_we !== 1'b0 || retire_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL flush_bubble: got we=%b cnt=%0d exp 0/%0d", rf_we, retire_count, exp_cnt);
        end
        hold = 1'b1;
        step();
        checks++;
        if (rf_we !== 1'b0 || retire_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL flush_and_hold: got we=%b cnt=%0d exp 0/%0d", rf_we, retire_count, exp_cnt);
        end
        hold = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd5);
        step();
        exp_cnt++;
        // Flush raised after the accepting edge must not cancel the registered pulse.
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h66, 5'd6);
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55) begin
            errors++;
            $display("FAIL late_flush_pulse: got we=%b waddr=%0d wdata=%h exp 1/5/00000055", rf_we, rf_waddr, rf_wdata);
        end
        step();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || retire_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL late_flush_after: got we=%b waddr=%0d cnt=%0d exp 0/5/%0d", rf_we, rf_waddr, retire_count, exp_cnt);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] alu_vals [3];
        alu_vals[0] = 32'h11;
        alu_vals[1] = 32'h22;
        alu_vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, alu_vals[i], 5'(i + 1));
            step();
            exp_cnt++;
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(i + 1) || rf_wdata !== alu_vals[i] || fwd_reg !== 5'(i + 1)) begin
                errors++;
                $display("FAIL b2b_%0d: got we=%b waddr=%0d wdata=%h fwd=%0d exp 1/%0d/%h/%0d",
                         i, rf_we, rf_waddr, rf_wdata, fwd_reg, i + 1, alu_vals[i], i + 1);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (rf_we !== 1'b0 || retire_count !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL b2b_end: got we=%b cnt=%0d exp 0/%0d", rf_we, retire_count, exp_cnt);
        end
    endtask

`ifdef WB_LOAD_EXT_EN
    task automatic test_load_ext();
        logic [1:0]  sizes [6];
        logic        unsg  [6];
        logic [1:0]  offs  [6];
        logic [31:0] exps  [6];
        sizes[0] = 2'b00; unsg[0] = 1'b0; offs[0] = 2'd1; exps[0] = 32'h0000_007F;
        sizes[1] = 2'b00; unsg[1] = 1'b0; offs[1] = 2'd3; exps[1] = 32'hFFFF_FF80;
        sizes[2] = 2'b01; unsg[2] = 1'b1; offs[2] = 2'd2; exps[2] = 32'h0000_80FF;
        sizes[3] = 2'b10; unsg[3] = 1'b0; offs[3] = 2'd0; exps[3] = 32'h80FF_7F19;
        sizes[4] = 2'b00; unsg[4] = 1'b1; offs[4] = 2'd3; exps[4] = 32'h0000_0080;
        sizes[5] = 2'b01; unsg[5] = 1'b0; offs[5] = 2'd2; exps[5] = 32'hFFFF_80FF;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h80FF_7F19, 32'h0, 5'd10);
            in_load_size = sizes[i];
            in_load_unsigned = unsg[i];
            in_byte_off = offs[i];
            step();
            exp_cnt++;
            checks++;
            if (rf_we !== 1'b1 || rf_wdata !== exps[i]) begin
                errors++;
                $display("FAIL ext_%0d: got we=%b wdata=%h exp 1/%h", i, rf_we, rf_wdata, exps[i]);
            end
        end
        in_load_size = 2'b10;
        in_load_unsigned = 1'b0;
        in_byte_off = 2'b00;
        in_valid = 1'b0;
        step();
    endtask
`endif

    task automatic test_wrap();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h1, 5'd7);
        for (int i = 0; i < 17; i++) begin
            step();
            exp_cnt++;
            if (i == 15) begin
                checks++;
                if (retire_count4 !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap_16: got %0d exp 0", retire_count4);
                end
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (retire_count4 !== 4'd1 || retire_count !== 32'd17) begin
            errors++;
            $display("FAIL wrap_17: got %0d/%0d exp 1/17", retire_count4, retire_count);
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_r0_nowrite();
        test_hold_flush();
        test_back_to_back();
`ifdef WB_LOAD_EXT_EN
        test_load_ext();
`endif
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
